// File: rtl/fifo_bank_sequencer.sv
// fifo_bank_sequencer: walks a masked bank of FIFOs one at a time,
// flushing, filling with a known pattern, draining and checking each.
module fifo_bank_sequencer #(
  parameter int NUM_FIFO  = 8,
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 512
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_FIFO-1:0]  fifo_mask_i,
  input  logic [9:0]           burst_len_i,
  input  logic [NUM_FIFO-1:0]  full_i,
  input  logic [NUM_FIFO-1:0]  empty_i,
  input  logic [DATAWIDTH-1:0] rd_data_i,
  output logic [NUM_FIFO-1:0]  push_o,
  output logic [NUM_FIFO-1:0]  pop_o,
  output logic [NUM_FIFO-1:0]  flush_o,
  output logic [DATAWIDTH-1:0] push_data_o,
  output logic [2:0]           fifo_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           err_code_o,
  output logic [3:0]           pass_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEXT   = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [10:0] MAX_LEN = 11'(DEPTH);

  logic [2:0]          state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [3:0]          srch_q, srch_d;
  logic [NUM_FIFO-1:0] mask_q, mask_d;
  logic [9:0]          len_q, len_d;
  logic [9:0]          idx_q, idx_d;
  logic                settle_q, settle_d;
  logic [1:0]          err_q, err_d;
  logic [3:0]          pass_q, pass_d;

  logic [NUM_FIFO-1:0]  sel_oh;
  logic                 full_sel;
  logic                 empty_sel;
  logic                 nxt_found;
  logic [2:0]           nxt_sel;
  logic [9:0]           len_sat;
  logic [9:0]           idx_inc;
  logic [DATAWIDTH-1:0] exp_word;
  logic                 cmp_en;
  logic                 bad;
  logic                 do_push;
  logic                 do_pop;
  logic [3:0]           pass_inc;

  function automatic logic [DATAWIDTH-1:0] pat(
    input logic [2:0] s,
    input logic [9:0] i
  );
    logic [15:0] p;
    p = {s, 3'b000, i};
    return DATAWIDTH'(p);
  endfunction

  assign sel_oh    = NUM_FIFO'(1) << sel_q;
  assign full_sel  = |(full_i & sel_oh);
  assign empty_sel = |(empty_i & sel_oh);
  assign idx_inc   = idx_q + 10'd1;
  assign len_sat   = ({1'b0, burst_len_i} > MAX_LEN) ? MAX_LEN[9:0] : burst_len_i;
  assign pass_inc  = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;

  // Read data trails each pop by one cycle, so check the previous word.
  assign exp_word = pat(sel_q, idx_q - 10'd1);
  assign cmp_en   = ((state_q == S_DRAIN) && (idx_q != 10'd0)) ||
                    (state_q == S_CHECK);
  assign bad      = cmp_en && (rd_data_i != exp_word);
  assign do_push  = (state_q == S_FILL) && !full_sel;
  assign do_pop   = (state_q == S_DRAIN) && !bad && !empty_sel;

  // Strobes are gated by abort in the same cycle.
  assign push_o      = (do_push && !abort_i) ? sel_oh : '0;
  assign pop_o       = (do_pop && !abort_i) ? sel_oh : '0;
  assign flush_o     = ((state_q == S_FLUSH) && !abort_i) ? sel_oh : '0;
  assign push_data_o = pat(sel_q, idx_q);
  assign fifo_sel_o  = sel_q;
  // busy drops as done pulses, so an empty pass is busy for one cycle.
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE) && !abort_i;
  assign error_o     = |err_q;
  assign err_code_o  = err_q;
  assign pass_cnt_o  = pass_q;

  // Lowest masked FIFO at or above the search index.
  always_comb begin
    nxt_found = 1'b0;
    nxt_sel   = 3'd0;
    for (int i = NUM_FIFO - 1; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= srch_q)) begin
        nxt_found = 1'b1;
        nxt_sel   = 3'(i);
      end
    end
  end

  // Pass sequencing and error capture.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    srch_d   = srch_q;
    mask_d   = mask_q;
    len_d    = len_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    pass_d   = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d  = fifo_mask_i;
          len_d   = len_sat;
          err_d   = 2'd0;
          pass_d  = 4'd0;
          srch_d  = 4'd0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (nxt_found) begin
          sel_d   = nxt_sel;
          state_d = S_FLUSH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FLUSH: begin
        settle_d = 1'b0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = 1'b1;
        idx_d    = 10'd0;
        if (settle_q) begin
          if (len_q == 10'd0) begin
            pass_d  = pass_inc;
            srch_d  = {1'b0, sel_q} + 4'd1;
            state_d = S_NEXT;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (full_sel) begin
          err_d   = 2'd1;
          state_d = S_DONE;
        end else if (idx_inc == len_q) begin
          idx_d   = 10'd0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_inc;
        end
      end
      S_DRAIN: begin
        if (bad) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else if (empty_sel) begin
          err_d   = 2'd2;
          state_d = S_DONE;
        end else begin
          idx_d = idx_inc;
          if (idx_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          pass_d  = pass_inc;
          srch_d  = {1'b0, sel_q} + 4'd1;
          state_d = S_NEXT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = err_q;
      pass_d  = pass_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      srch_q   <= 4'd0;
      mask_q   <= '0;
      len_q    <= 10'd0;
      idx_q    <= 10'd0;
      settle_q <= 1'b0;
      err_q    <= 2'd0;
      pass_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      srch_q   <= srch_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

endmodule

// File: tb/tb_fifo_bank_sequencer.sv
// tb_fifo_bank_sequencer: FIFO bank environment plus a timeline model
// of every pass, compared against the sequencer each cycle.
module tb_fifo_bank_sequencer;

  localparam int NF = 8;
  localparam int DW = 16;
  localparam int DP = 512;

  logic          clk = 1'b0;
  logic          WBs_RST_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [NF-1:0] fifo_mask_i = '0;
  logic [9:0]    burst_len_i = '0;
  logic [NF-1:0] full_i;
  logic [NF-1:0] empty_i;
  logic [DW-1:0] rd_data_i = '0;
  logic [NF-1:0] push_o, pop_o, flush_o;
  logic [DW-1:0] push_data_o;
  logic [2:0]    fifo_sel_o;
  logic          busy_o, done_o, error_o;
  logic [1:0]    err_code_o;
  logic [3:0]    pass_cnt_o;

  always #5 clk = ~clk;

  fifo_bank_sequencer #(.NUM_FIFO(NF), .DATAWIDTH(DW), .DEPTH(DP)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(WBs_RST_i),
    .start_i(start_i), .abort_i(abort_i),
    .fifo_mask_i(fifo_mask_i), .burst_len_i(burst_len_i),
    .full_i(full_i), .empty_i(empty_i), .rd_data_i(rd_data_i),
    .push_o(push_o), .pop_o(pop_o), .flush_o(flush_o),
    .push_data_o(push_data_o), .fifo_sel_o(fifo_sel_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_code_o(err_code_o), .pass_cnt_o(pass_cnt_o)
  );

  typedef struct {
    logic [7:0]  push, pop, flush;
    logic [15:0] data;
    logic [2:0]  sel;
    logic        busy, done;
    logic [1:0]  err;
    logic [3:0]  pass;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  int f_kind = 0, f_idx = 0, f_k = 0;
  logic [1:0] m_err = 2'd0;
  logic [3:0] m_pass = 4'd0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int f, input int w);
    return {3'(f), 3'b000, 10'(w)};
  endfunction

  // kind: 0 no strobe, 1 flush, 2 push, 3 pop
  task automatic emit(input int kind, input int f, input int w,
                      input logic busy, input logic done);
    exp_t e;
    e.push = '0; e.pop = '0; e.flush = '0;
    e.data = pat(f, w); e.sel = 3'(f);
    e.busy = busy; e.done = done; e.err = m_err; e.pass = m_pass;
    case (kind)
      1: e.flush = 8'(1) << f;
      2: e.push = 8'(1) << f;
      3: e.pop = 8'(1) << f;
      default: ;
    endcase
    exp_q.push_back(e);
  endtask

  // Cycle-by-cycle timeline of a whole pass, starting at the start cycle.
  task automatic build(input logic [7:0] m, input int l);
    int L;
    bit stop;
    L = (l > DP) ? DP : l;
    stop = 0;
    exp_q.delete();
    emit(0, 0, 0, 1'b0, 1'b0);
    m_err = 2'd0;
    m_pass = 4'd0;
    emit(0, 0, 0, 1'b1, 1'b0);
    for (int f = 0; f < NF; f++) begin
      if (m[f] && !stop) begin
        emit(1, f, 0, 1'b1, 1'b0);
        emit(0, f, 0, 1'b1, 1'b0);
        emit(0, f, 0, 1'b1, 1'b0);
        for (int w = 0; w < L && !stop; w++) begin
          if (f_kind == 1 && f == f_idx && w == f_k) begin
            emit(0, f, 0, 1'b1, 1'b0); m_err = 2'd1; stop = 1;
          end else emit(2, f, w, 1'b1, 1'b0);
        end
        for (int p = 0; p < L && !stop; p++) begin
          if (f_kind == 3 && f == f_idx && p == f_k + 1) begin
            emit(0, f, 0, 1'b1, 1'b0); m_err = 2'd3; stop = 1;
          end else if (f_kind == 2 && f == f_idx && p == f_k) begin
            emit(0, f, 0, 1'b1, 1'b0); m_err = 2'd2; stop = 1;
          end else emit(3, f, p, 1'b1, 1'b0);
        end
        if (L > 0 && !stop) begin
          if (f_kind == 3 && f == f_idx && f_k == L - 1) begin
            emit(0, f, 0, 1'b1, 1'b0); m_err = 2'd3; stop = 1;
          end else emit(0, f, 0, 1'b1, 1'b0);
        end
        if (!stop) begin
          if (m_pass != 4'hF) m_pass = m_pass + 4'd1;
          emit(0, f, 0, 1'b1, 1'b0);
        end
      end
    end
    emit(0, 0, 0, 1'b0, 1'b1);
  endtask

  // FIFO bank environment.
  logic [15:0] fq[NF][$];
  int pushc[NF], popc[NF], cnt[NF];
  int push_tot = 0, pop_tot = 0, flush_tot = 0, busy_tot = 0, done_tot = 0;
  logic [15:0] push_log[$];
  logic [15:0] env_d;

  always @(posedge clk) begin
    if (busy_o) busy_tot++;
    if (done_o) done_tot++;
    for (int i = 0; i < NF; i++) begin
      if (flush_o[i]) begin
        fq[i].delete(); pushc[i] = 0; popc[i] = 0; flush_tot++;
      end
      if (push_o[i]) begin
        fq[i].push_back(push_data_o);
        push_log.push_back(push_data_o);
        pushc[i]++; push_tot++;
      end
      if (pop_o[i]) begin
        if (fq[i].size() > 0) env_d = fq[i].pop_front();
        else env_d = 16'hDEAD;
        if (f_kind == 3 && i == f_idx && popc[i] == f_k) env_d = env_d ^ 16'h8000;
        rd_data_i <= env_d;
        popc[i]++; pop_tot++;
      end
      cnt[i] = fq[i].size();
    end
  end

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      full_i[i]  = (cnt[i] >= DP) || (f_kind == 1 && i == f_idx && pushc[i] == f_k);
      empty_i[i] = (cnt[i] == 0) || (f_kind == 2 && i == f_idx && popc[i] == f_k);
    end
  end

  // Per-cycle compare against the timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else begin
        cur.push = '0; cur.pop = '0; cur.flush = '0; cur.data = '0; cur.sel = '0;
        cur.busy = 1'b0; cur.done = 1'b0; cur.err = m_err; cur.pass = m_pass;
      end
      chk("outputs",
          {push_o, pop_o, flush_o, busy_o, done_o, error_o, err_code_o, pass_cnt_o},
          {cur.push, cur.pop, cur.flush, cur.busy, cur.done, (cur.err != 2'd0),
           cur.err, cur.pass});
      if (cur.push != 8'd0) chk("push_data", push_data_o, cur.data);
      if ((cur.push | cur.pop | cur.flush) != 8'd0) chk("fifo_sel", fifo_sel_o, cur.sel);
    end
  end

  int s_push, s_pop, s_flush, s_busy, s_done;

  task automatic snap();
    s_push = push_tot; s_pop = pop_tot; s_flush = flush_tot;
    s_busy = busy_tot; s_done = done_tot;
    push_log.delete();
  endtask

  task automatic run(input logic [7:0] m, input logic [9:0] l,
                     input int kind, input int fi, input int fk);
    int b;
    f_kind = kind; f_idx = fi; f_k = fk;
    @(posedge clk); #1;
    snap();
    build(m, int'(l));
    fifo_mask_i = m; burst_len_i = l; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    b = 0;
    while (exp_q.size() > 0 && b < 3000) begin
      @(posedge clk); b++;
    end
    chk("run_timeout", 64'(b >= 3000), 0);
    if (b >= 3000) exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [51:0] all_out();
    return {push_o, pop_o, flush_o, push_data_o, fifo_sel_o,
            busy_o, done_o, error_o, err_code_o, pass_cnt_o};
  endfunction

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", all_out(), 0);
    WBs_RST_i = 1'b0;
    chk_en = 1'b1;

    run(8'h05, 10'd4, 0, 0, 0);
    chk("r042_pass", pass_cnt_o, 2);
    chk("r042_err", error_o, 0);
    chk("r042_pushes", push_tot - s_push, 8);
    chk("r042_pops", pop_tot - s_pop, 8);
    chk("r042_flushes", flush_tot - s_flush, 2);
    chk("r042_word3", push_log[3], 16'h0003);
    chk("r042_word4", push_log[4], 16'h4000);
    chk("r042_word7", push_log[7], 16'h4003);

    run(8'h01, 10'd512, 1, 0, 300);
    chk("r043_pushes", push_tot - s_push, 300);
    chk("r043_err", err_code_o, 1);
    chk("r043_pass", pass_cnt_o, 0);
    chk("r043_done", done_tot - s_done, 1);

    run(8'h02, 10'd8, 3, 1, 2);
    chk("r044_pops", pop_tot - s_pop, 3);
    chk("r044_err", err_code_o, 3);
    chk("r044_pass", pass_cnt_o, 0);

    run(8'h00, 10'd4, 0, 0, 0);
    chk("mask0_busy_cycles", busy_tot - s_busy, 1);
    chk("mask0_done", done_tot - s_done, 1);
    chk("mask0_err_cleared", error_o, 0);

    run(8'hFF, 10'd0, 0, 0, 0);
    chk("len0_flushes", flush_tot - s_flush, 8);
    chk("len0_pushes", push_tot - s_push, 0);
    chk("len0_pops", pop_tot - s_pop, 0);
    chk("len0_pass", pass_cnt_o, 8);

    run(8'h08, 10'd3, 2, 3, 1);
    chk("under_err", err_code_o, 2);
    chk("under_pops", pop_tot - s_pop, 1);

    run(8'h80, 10'd600, 0, 0, 0);
    chk("sat_pushes", push_tot - s_push, 512);
    chk("sat_last_word", push_log[511], 16'hE1FF);
    chk("sat_pass", pass_cnt_o, 1);

    chk_en = 1'b0;
    f_kind = 0;
    @(posedge clk); #1;
    snap();
    fifo_mask_i = 8'h03; burst_len_i = 10'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    b = 0;
    while (push_o != 8'h02 && b < 50) begin
      @(negedge clk); b++;
    end
    chk("abort_reach_fill", push_o, 8'h02);
    abort_i = 1'b1;
    #1;
    chk("abort_strobes", {push_o, pop_o, flush_o}, 0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_idle", {busy_o, done_o}, 0);
    chk("abort_hold_pass", pass_cnt_o, 1);
    chk("abort_hold_err", err_code_o, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_tot - s_done, 0);

    snap();
    fifo_mask_i = 8'h04; burst_len_i = 10'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    b = 0;
    while (pop_o == 8'h00 && b < 50) begin
      @(negedge clk); b++;
    end
    chk("rst_reach_drain", pop_o, 8'h04);
    WBs_RST_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", all_out(), 0);
    WBs_RST_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_done", done_tot - s_done, 0);

    m_err = 2'd0;
    m_pass = 4'd0;
    chk_en = 1'b1;
    run(8'h01, 10'd1, 0, 0, 0);
    chk("recover_pass", pass_cnt_o, 1);
    chk("recover_pushes", push_tot - s_push, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
